dmem_ctrl: RTL

DMEM_CTRL -- requirements
Module: dmem_ctrl

---
 rtl/dmem_pkg.sv | 48 ++++
 rtl/dmem_ctrl_load_align.sv | 24 ++
 rtl/dmem_ctrl.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared width codes, FSM encoding and lane helpers for the data-memory controller.
// Pure declarations: no latency, no flow control of its own.
package dmem_pkg;

    localparam logic [1:0] W_BYTE = 2'b00;
    localparam logic [1:0] W_HALF = 2'b01;
    localparam logic [1:0] W_WORD = 2'b10;
    localparam logic [1:0] W_ILL  = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_BUSY = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

    localparam int TIMEOUT_DEFAULT = 255;

    // Request captured in IDLE and held stable for the whole bus transaction.
    typedef struct packed {
        logic [31:0] addr;
        logic [1:0]  width;
        logic        sign;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } req_t;

    function automatic logic [3:0] byte_en(input logic [1:0] width, input logic [1:0] off);
        case (width)
            W_BYTE:  return 4'b0001 << off;
            W_HALF:  return off[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_rep(input logic [1:0] width, input logic [31:0] data);
        case (width)
            W_BYTE:  return {4{data[7:0]}};
            W_HALF:  return {2{data[15:0]}};
            default: return data;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [1:0] width, input logic [1:0] off);
        return (width == W_ILL) ||
               ((width == W_HALF) && off[0]) ||
               ((width == W_WORD) && (off != 2'b00));
    endfunction

endpackage

// File: rtl/dmem_ctrl_load_align.sv
// Load data aligner: shifts the addressed lane down, truncates to width, extends.
// Purely combinational, zero latency, no backpressure.
module load_align
    import dmem_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  off_i,
    input  logic [1:0]  width_i,
    input  logic        sign_i,
    output logic [31:0] data_o
);

    logic [31:0] shifted;

    always_comb begin
        shifted = word_i >> {off_i, 3'b000};
        case (width_i)
            W_BYTE:  data_o = {{24{sign_i & shifted[7]}}, shifted[7:0]};
            W_HALF:  data_o = {{16{sign_i & shifted[15]}}, shifted[15:0]};
            default: data_o = shifted;
        endcase
    end

endmodule

// File: rtl/dmem_ctrl.sv
// MEM-stage data-memory controller: one outstanding request, ack-terminated, with timeout.
// Stalls the pipeline from request issue until ack (or timeout); load data lands one cycle after ack.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        mem_read_i,
    input  logic        mem_write_i,
    input  logic [1:0]  mem_width_i,
    input  logic        mem_sign_extend_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic        flush_i,
    output logic        stall_o,
    output logic [31:0] rdata_o,
    output logic        misaligned_o,
    output logic        bus_error_o,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [3:0]  dmem_be_o,
    output logic [31:0] dmem_wdata_o,
    input  logic        dmem_ack_i,
    input  logic [31:0] dmem_rdata_i
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [1:0]       state_q, state_d;
    req_t             req_q, req_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             squash_q, squash_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             mis_q, mis_d;
    logic             berr_q, berr_d;

    logic        op;
    logic        fault;
    logic        start;
    logic        kill;
    logic [31:0] load_data;

    load_align u_load_align (
        .word_i  (dmem_rdata_i),
        .off_i   (req_q.addr[1:0]),
        .width_i (req_q.width),
        .sign_i  (req_q.sign),
        .data_o  (load_data)
    );

    assign op    = mem_read_i | mem_write_i;
    assign fault = is_misaligned(mem_width_i, addr_i[1:0]);
    assign start = (state_q == ST_IDLE) && op && !flush_i && !fault;
    // A flush arriving in the ack cycle itself squashes just like an earlier one.
    assign kill  = squash_q | flush_i;

    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        cnt_d    = cnt_q;
        squash_d = squash_q;
        rdata_d  = rdata_q;
        mis_d    = 1'b0;
        berr_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (op && !flush_i) begin
                    if (fault) begin
                        mis_d = 1'b1;
                    end else begin
                        req_d.addr  = addr_i;
                        req_d.width = mem_width_i;
                        req_d.sign  = mem_sign_extend_i;
                        req_d.we    = mem_write_i;
                        req_d.be    = byte_en(mem_width_i, addr_i[1:0]);
                        req_d.wdata = store_rep(mem_width_i, wdata_i);
                        cnt_d       = '0;
                        squash_d    = 1'b0;
                        state_d     = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                if (dmem_ack_i) begin
                    if (!req_q.we && !kill) begin
                        rdata_d = load_data;
                    end
                    state_d  = kill ? ST_IDLE : ST_DONE;
                    squash_d = 1'b0;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    berr_d   = 1'b1;
                    squash_d = 1'b0;
                    state_d  = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (flush_i) begin
                        squash_d = 1'b1;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q  <= ST_IDLE;
            req_q    <= '0;
            cnt_q    <= '0;
            squash_q <= 1'b0;
            rdata_q  <= '0;
            mis_q    <= 1'b0;
            berr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            cnt_q    <= cnt_d;
            squash_q <= squash_d;
            rdata_q  <= rdata_d;
            mis_q    <= mis_d;
            berr_q   <= berr_d;
        end
    end

    // Stall is combinational in IDLE so the issuing instruction is held in the same cycle.
    assign stall_o      = rst_i & (start | (state_q == ST_BUSY));
    assign rdata_o      = rdata_q;
    assign misaligned_o = mis_q;
    assign bus_error_o  = berr_q;
    assign dmem_req_o   = (state_q == ST_BUSY);
    assign dmem_we_o    = req_q.we;
    assign dmem_addr_o  = {req_q.addr[31:2], 2'b00};
    assign dmem_be_o    = req_q.be;
    assign dmem_wdata_o = req_q.wdata;

endmodule
